// File: rtl/abs_diff_pkg.sv
// rtl/abs_diff_pkg.sv - shared types and |x-y| helper for the abs-diff blocks
//
// Purpose:
//   Holds the scan FSM state type and the fixed-width absolute-difference
//   function that the LED display top also uses.
// Contents:
//   state_t   - IDLE / RUN / DONE, 2-bit encoding
//   LED_W     - operand width of the LED display path
//   abs_diff  - returns {sign, diff}; sign = 1 when x < y
package abs_diff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LED_W = 5;

  function automatic logic [LED_W:0] abs_diff(input logic [LED_W-1:0] x,
                                               input logic [LED_W-1:0] y);
    logic [LED_W-1:0] d;
    // Subtract the smaller from the larger so the result never wraps.
    d = (x > y) ? (x - y) : (y - x);
    return {(x < y), d};
  endfunction

endpackage

// File: rtl/abs_diff_unit.sv
// rtl/abs_diff_unit.sv - combinational W-bit absolute difference with sign
//
// Purpose:
//   Computes |x-y| and the direction flag for one channel. The scan top
//   time-shares a single instance across all channels.
// Ports:
//   i_x, i_y  - unsigned W-bit operands
//   o_diff    - |i_x - i_y|, W bits, cannot overflow
//   o_sign    - 1 when i_x < i_y (equal operands give 0)
module abs_diff_unit
  import abs_diff_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_diff,
  output logic         o_sign
);

  generate
    if (W == LED_W) begin : g_shared
      // Same width as the LED path: reuse the package function so both
      // blocks agree bit-for-bit.
      logic [W:0] w_res;
      assign w_res  = abs_diff(i_x, i_y);
      assign o_sign = w_res[W];
      assign o_diff = w_res[W-1:0];
    end else begin : g_generic
      assign o_diff = (i_x > i_y) ? (i_x - i_y) : (i_y - i_x);
      assign o_sign = (i_x < i_y);
    end
  endgenerate

endmodule

// File: rtl/abs_diff_scan.sv
// rtl/abs_diff_scan.sv - time-multiplexed N-channel |x-y| scanner with aggregates
//
// Purpose:
//   Accepts N operand pairs plus a threshold, walks the channels one per
//   clock through a shared abs_diff_unit, and presents per-channel
//   differences/signs together with the sum, arg-max and over-threshold count.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake (ready only in IDLE)
//   x_in, y_in            - N*W packed operands, channel k at [k*W +: W]
//   thresh                - threshold, captured with the operands
//   out_valid / out_ready - result handshake
//   diff_out, sign_out    - per-channel |x-y| and (x<y) flags
//   sum_out               - sum of all channel differences
//   max_idx               - channel of largest difference, lowest on tie
//   over_cnt              - channels whose difference is strictly > thresh
//   busy                  - high whenever the FSM is not IDLE
module abs_diff_scan
  import abs_diff_pkg::*;
#(
  parameter int W     = 5,
  parameter int N     = 4,
  parameter int ACC_W = W + $clog2(N) + 1,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   x_in,
  input  logic [N*W-1:0]   y_in,
  input  logic [W-1:0]     thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   diff_out,
  output logic [N-1:0]     sign_out,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] over_cnt,
  output logic             busy
);

  // Channel counter only needs to address 0..N-1.
  localparam int CH_W = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  state_t           w_state_next;

  logic [W-1:0]     r_x [N];
  logic [W-1:0]     r_y [N];
  logic [W-1:0]     r_thresh;
  logic [CH_W-1:0]  r_ch;
  logic [W-1:0]     r_max;

  logic             r_out_valid;
  logic [N*W-1:0]   r_diff;
  logic [N-1:0]     r_sign;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_over_cnt;

  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_diff;
  logic             w_sign;
  logic             w_over;
  logic             w_new_max;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_ch == CH_W'(N - 1));
  assign w_over    = (w_diff > r_thresh);
  // Channel 0 seeds the running max; later channels need a strict win so
  // ties stay with the lower index.
  assign w_new_max = (r_ch == '0) || (w_diff > r_max);

  abs_diff_unit #(
    .W (W)
  ) u_abs_diff_unit (
    .i_x    (r_x[r_ch]),
    .i_y    (r_y[r_ch]),
    .o_diff (w_diff),
    .o_sign (w_sign)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    if (r_state == IDLE) begin
      in_ready = 1'b1;
      busy     = 1'b0;
    end
  end

  // Datapath: operand capture, per-channel writes and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
      r_thresh    <= '0;
      r_ch        <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_sign      <= '0;
      r_sum       <= '0;
      r_max_idx   <= '0;
      r_over_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < N; k++) begin
              r_x[k] <= x_in[k*W +: W];
              r_y[k] <= y_in[k*W +: W];
            end
            r_thresh   <= thresh;
            r_ch       <= '0;
            r_max      <= '0;
            r_diff     <= '0;
            r_sign     <= '0;
            r_sum      <= '0;
            r_max_idx  <= '0;
            r_over_cnt <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (r_ch == CH_W'(k)) begin
              r_diff[k*W +: W] <= w_diff;
              r_sign[k]        <= w_sign;
            end
          end
          r_sum      <= r_sum + ACC_W'(w_diff);
          r_over_cnt <= r_over_cnt + CNT_W'(w_over);
          if (w_new_max) begin
            r_max     <= w_diff;
            r_max_idx <= CNT_W'(r_ch);
          end
          if (w_last) begin
            r_out_valid <= 1'b1;
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        DONE: begin
          // Results stay put after the handshake until the next accept.
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign diff_out  = r_diff;
  assign sign_out  = r_sign;
  assign sum_out   = r_sum;
  assign max_idx   = r_max_idx;
  assign over_cnt  = r_over_cnt;

endmodule

// File: tb/tb_abs_diff_scan.sv
// tb/tb_abs_diff_scan.sv - self-checking bench for abs_diff_scan
module tb_abs_diff_scan;

  localparam int W     = 5;
  localparam int N     = 4;
  localparam int ACC_W = W + $clog2(N) + 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef struct packed {
    logic [N*W-1:0]   diff;
    logic [N-1:0]     sign;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] over;
  } res_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   x_in;
  logic [N*W-1:0]   y_in;
  logic [W-1:0]     thresh;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   diff_out;
  logic [N-1:0]     sign_out;
  logic [ACC_W-1:0] sum_out;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] over_cnt;
  logic             busy;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  abs_diff_scan #(
    .W (W),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_out  (diff_out),
    .sign_out  (sign_out),
    .sum_out   (sum_out),
    .max_idx   (max_idx),
    .over_cnt  (over_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d required finish earlier", cyc);
    $fatal(1);
  end

  function automatic res_t model(input logic [N*W-1:0] x, input logic [N*W-1:0] y,
                                 input logic [W-1:0] th);
    res_t         r;
    logic [W-1:0] xv, yv, d, mx;
    r  = '0;
    mx = '0;
    for (int k = 0; k < N; k++) begin
      xv = x[k*W +: W];
      yv = y[k*W +: W];
      d  = (xv >= yv) ? xv - yv : yv - xv;
      r.diff[k*W +: W] = d;
      r.sign[k]        = (xv < yv);
      r.sum            = r.sum + ACC_W'(d);
      if (k == 0 || d > mx) begin
        mx    = d;
        r.idx = CNT_W'(k);
      end
      if (d > th) r.over = r.over + CNT_W'(1);
    end
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.diff = diff_out;
    r.sign = sign_out;
    r.sum  = sum_out;
    r.idx  = max_idx;
    r.over = over_cnt;
    return r;
  endfunction

  // Drives one operand set through the input handshake; returns at the
  // negedge following the accept edge.
  task automatic send(input logic [N*W-1:0] x, input logic [N*W-1:0] y,
                      input logic [W-1:0] th, output int acc_cyc);
    bit ok;
    ok      = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_ready_timeout in_ready=%0b required 1", in_ready);
      return;
    end
    x_in     = x;
    y_in     = y;
    thresh   = th;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts rising edges after accept.
  task automatic collect(output res_t got, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    got = sample();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL result_timeout out_valid=%0b required 1 within 40 cycles", out_valid);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    x_in      = {5'd1, 5'd2, 5'd3, 5'd4};
    y_in      = {5'd9, 5'd9, 5'd9, 5'd9};
    thresh    = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_dominates busy=%0b required 0", busy); end
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (sample() !== res_t'(0)) begin errors++; $display("FAIL reset_outputs got=%h exp=0", sample()); end
  endtask

  task automatic test_basic();
    res_t got, exp;
    int   lat, acc;
    logic [N*W-1:0] x, y;
    x = {5'd7, 5'd31, 5'd10, 5'd5};
    y = {5'd7, 5'd0,  5'd5,  5'd10};
    exp_q.push_back(model(x, y, 5'd4));
    send(x, y, 5'd4, acc);
    // Operand changes after acceptance must not leak into the result.
    x_in   = '1;
    y_in   = '0;
    thresh = '0;
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== N) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_result got=%h exp=%h", got, exp); end
    checks++;
    if (diff_out !== {5'd0, 5'd31, 5'd5, 5'd5} || sign_out !== 4'b0001)
      begin errors++; $display("FAIL basic_diff_sign got=%h/%b exp=%h/0001", diff_out, sign_out, {5'd0, 5'd31, 5'd5, 5'd5}); end
    checks++;
    if (sum_out !== 8'd41 || max_idx !== 3'd2 || over_cnt !== 3'd3)
      begin errors++; $display("FAIL basic_aggregates got=%0d/%0d/%0d exp=41/2/3", sum_out, max_idx, over_cnt); end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL basic_handshake out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_extremes();
    res_t got, exp;
    int   lat, acc;
    exp_q.push_back(model({N{5'd31}}, {N{5'd0}}, 5'd31));
    send({N{5'd31}}, {N{5'd0}}, 5'd31, acc);
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL extremes_result got=%h exp=%h", got, exp); end
    checks++;
    if (sum_out !== 8'd124 || max_idx !== 3'd0 || over_cnt !== 3'd0 || sign_out !== 4'b0000)
      begin errors++; $display("FAIL extremes_aggregates got=%0d/%0d/%0d/%b exp=124/0/0/0000", sum_out, max_idx, over_cnt, sign_out); end
    release_result();
  endtask

  task automatic test_equal();
    res_t got, exp;
    int   lat, acc;
    exp_q.push_back(model({N{5'd9}}, {N{5'd9}}, 5'd0));
    send({N{5'd9}}, {N{5'd9}}, 5'd0, acc);
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL equal_result got=%h exp=%h", got, exp); end
    checks++;
    if (sum_out !== 8'd0 || max_idx !== 3'd0 || over_cnt !== 3'd0 || diff_out !== '0)
      begin errors++; $display("FAIL equal_aggregates got=%0d/%0d/%0d exp=0/0/0", sum_out, max_idx, over_cnt); end
    release_result();
  endtask

  task automatic test_backpressure();
    res_t got, exp, snap;
    int   lat, acc, bad_stable, bad_ready;
    logic [N*W-1:0] x, y;
    x = {5'd3, 5'd20, 5'd1, 5'd12};
    y = {5'd8, 5'd2, 5'd1, 5'd30};
    exp_q.push_back(model(x, y, 5'd6));
    send(x, y, 5'd6, acc);
    collect(got, lat);
    exp  = exp_q.pop_front();
    snap = got;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_result got=%h exp=%h", got, exp); end
    bad_stable = 0;
    bad_ready  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      x_in     = N*W'($urandom);
      y_in     = N*W'($urandom);
      thresh   = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || sample() !== snap) bad_stable++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad_stable != 0) begin errors++; $display("FAIL bp_stable unstable_cycles=%0d exp=0", bad_stable); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL bp_in_ready high_cycles=%0d exp=0", bad_ready); end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_handshake out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready); end
    checks++;
    if (sample() !== exp) begin errors++; $display("FAIL bp_hold_after got=%h exp=%h", sample(), exp); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue busy=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    res_t got, exp;
    int   lat, acc, seen;
    send({5'd1, 5'd2, 5'd3, 5'd4}, {5'd20, 5'd20, 5'd20, 5'd20}, 5'd1, acc);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmr_busy_before got=%0b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL rmr_ctrl out_valid=%0b in_ready=%0b busy=%0b exp 0/1/0", out_valid, in_ready, busy); end
    checks++;
    if (sample() !== res_t'(0)) begin errors++; $display("FAIL rmr_outputs got=%h exp=0", sample()); end
    seen = 0;
    repeat (N + 2) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rmr_no_result out_valid_cycles=%0d exp=0", seen); end
    exp_q.push_back(model({5'd17, 5'd4, 5'd25, 5'd0}, {5'd2, 5'd4, 5'd30, 5'd11}, 5'd5));
    send({5'd17, 5'd4, 5'd25, 5'd0}, {5'd2, 5'd4, 5'd30, 5'd11}, 5'd5, acc);
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rmr_fresh_result got=%h exp=%h", got, exp); end
    release_result();
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int   lat, acc_a, acc_b;
    logic [N*W-1:0] xa, ya, xb, yb;
    xa = {5'd30, 5'd29, 5'd28, 5'd27};
    ya = {5'd0,  5'd1,  5'd2,  5'd3};
    xb = {5'd2,  5'd6,  5'd6,  5'd0};
    yb = {5'd3,  5'd0,  5'd0,  5'd1};
    out_ready = 1'b1;
    exp_q.push_back(model(xa, ya, 5'd10));
    send(xa, ya, 5'd10, acc_a);
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== N) begin errors++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, N); end
    exp_q.push_back(model(xb, yb, 5'd1));
    send(xb, yb, 5'd1, acc_b);
    checks++;
    if (acc_b - acc_a !== N + 2) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc_b - acc_a, N + 2); end
    collect(got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== N) begin errors++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, N); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0)
      begin errors++; $display("FAIL b2b_drain out_valid=%0b queue=%0d exp 0/0", out_valid, exp_q.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    thresh    = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_equal();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
